// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: program-load, control and datapath-select bus of the ALU sequencer (loop signal under ALU_SEQ_LOOP_EN)
interface alu_sequencer_if #(parameter int ADDR_W = 4) ();
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              clear;
    logic              start;
    logic              alu_ready;
    logic              issue_valid;
    logic [1:0]        sel_Ri;
    logic [1:0]        sel_Rj;
    logic [1:0]        sel_Rk;
    logic [1:0]        sel_op;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] pc;
`ifdef ALU_SEQ_LOOP_EN
    logic              loop;
`endif
    modport master (
`ifdef ALU_SEQ_LOOP_EN
        output loop,
`endif
        output load_valid, load_data, clear, start, alu_ready,
        input  load_ready, issue_valid, sel_Ri, sel_Rj, sel_Rk, sel_op, busy, done, error, pc
    );
    modport slave (
`ifdef ALU_SEQ_LOOP_EN
        input  loop,
`endif
        input  load_valid, load_data, clear, start, alu_ready,
        output load_ready, issue_valid, sel_Ri, sel_Rj, sel_Rk, sel_op, busy, done, error, pc
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues a loaded micro-program to the ALU datapath selects; ALU_SEQ_LOOP_EN enables looped execution
module alu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input logic           clk,
    input logic           reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state;
    logic [7:0]        mem [PROG_DEPTH];
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] pc;
    logic              done_q;
    logic              error_q;
    logic              load_ok;
    logic              accept;
    logic              last;
    logic              wrap;
`ifdef ALU_SEQ_LOOP_EN
    assign wrap = bus.loop;
`else
    assign wrap = 1'b0;
`endif
    assign bus.load_ready = (state == IDLE) && (count < (ADDR_W+1)'(PROG_DEPTH));
    assign load_ok        = bus.load_valid && bus.load_ready && !bus.clear;
    assign accept         = (state == RUN) && bus.alu_ready;
    assign last           = {1'b0, pc} == count - 1'b1;
    assign {bus.sel_op, bus.sel_Rk, bus.sel_Rj, bus.sel_Ri} = (state == RUN) ? mem[pc] : 8'd0;
    assign bus.issue_valid = state == RUN;
    assign bus.busy        = state == RUN;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.pc          = pc;
    always_ff @(posedge clk) begin
        if (load_ok) mem[count[ADDR_W-1:0]] <= bus.load_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pc      <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= accept && last;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear) count <= '0;
                    else begin
                        if (load_ok) count <= count + 1'b1;
                        if (bus.start) begin
                            // a same-cycle load makes an empty program non-empty
                            if (count != '0 || load_ok) begin
                                pc    <= '0;
                                state <= RUN;
                            end else error_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!last) pc <= pc + 1'b1;
                        else if (wrap) pc <= '0;
                        else state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pc    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (loop steps under ALU_SEQ_LOOP_EN)
module tb_alu_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0] sel;
    logic [7:0] exp_mem [16];
    alu_sequencer_if #(.ADDR_W(4)) bus ();
    alu_sequencer #(.PROG_DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    assign sel = {bus.sel_op, bus.sel_Rk, bus.sel_Rj, bus.sel_Ri};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data = 8'h00;
        bus.clear = 1'b0;
        bus.start = 1'b0;
        bus.alu_ready = 1'b0;
`ifdef ALU_SEQ_LOOP_EN
        bus.loop = 1'b0;
`endif
        #12;
        chk("rst_issue", bus.issue_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_sel", sel, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("idle_ready", bus.load_ready, 1);
        // basic three-word program
        bus.load_valid = 1'b1;
        bus.load_data = 8'h1B;
        step();
        bus.load_data = 8'h24;
        step();
        bus.load_data = 8'hC0;
        step();
        bus.load_valid = 1'b0;
        bus.start = 1'b1;
        bus.alu_ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("p3_i0_valid", bus.issue_valid, 1);
        chk("p3_i0_sel", sel, 8'h1B);
        chk("p3_i0_pc", bus.pc, 0);
        chk("p3_busy", bus.busy, 1);
        chk("p3_ready_run", bus.load_ready, 0);
        step();
        chk("p3_i1_sel", sel, 8'h24);
        chk("p3_i1_pc", bus.pc, 1);
        step();
        chk("p3_i2_sel", sel, 8'hC0);
        chk("p3_i2_pc", bus.pc, 2);
        chk("p3_i2_done", bus.done, 0);
        step();
        chk("p3_done", bus.done, 1);
        chk("p3_done_valid", bus.issue_valid, 0);
        chk("p3_done_busy", bus.busy, 0);
        chk("p3_done_sel", sel, 0);
        step();
        chk("p3_idle_done", bus.done, 0);
        chk("p3_idle_pc", bus.pc, 0);
        chk("p3_idle_ready", bus.load_ready, 1);
        // rerun with a stall at pc=1
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("st_pc0", bus.pc, 0);
        step();
        chk("st_pc1", bus.pc, 1);
        bus.alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_hold_pc", bus.pc, 1);
            chk("st_hold_sel", sel, 8'h24);
            chk("st_hold_valid", bus.issue_valid, 1);
        end
        bus.alu_ready = 1'b1;
        step();
        chk("st_resume_pc", bus.pc, 2);
        chk("st_resume_sel", sel, 8'hC0);
        step();
        chk("st_done", bus.done, 1);
        step();
        // empty-program start and start with same-cycle load
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("err_pulse", bus.error, 1);
        chk("err_valid", bus.issue_valid, 0);
        chk("err_busy", bus.busy, 0);
        step();
        chk("err_clear", bus.error, 0);
        chk("err_valid2", bus.issue_valid, 0);
        bus.start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = 8'h05;
        step();
        bus.start = 1'b0;
        bus.load_valid = 1'b0;
        chk("sl_valid", bus.issue_valid, 1);
        chk("sl_sel", sel, 8'h05);
        chk("sl_error", bus.error, 0);
        step();
        chk("sl_done", bus.done, 1);
        chk("sl_valid_end", bus.issue_valid, 0);
        step();
        // clear beats a same-cycle start and load
        bus.clear = 1'b1;
        bus.start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = 8'h3F;
        step();
        bus.clear = 1'b0;
        bus.load_valid = 1'b0;
        chk("clr_busy", bus.busy, 0);
        step();
        bus.start = 1'b0;
        chk("clr_empty_err", bus.error, 1);
        chk("clr_empty_busy", bus.busy, 0);
        step();
        // fill all 16 slots, then an ignored 17th load
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 37 + 3);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.load_data = exp_mem[i];
            step();
            chk("full_ready", bus.load_ready, (i < 15) ? 1 : 0);
        end
        bus.load_data = 8'hFF;
        step();
        bus.load_valid = 1'b0;
        chk("full_ready17", bus.load_ready, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("full_pc", bus.pc, i);
            chk("full_sel", sel, exp_mem[i]);
            chk("full_valid", bus.issue_valid, 1);
            step();
        end
        chk("full_done", bus.done, 1);
        chk("full_done_valid", bus.issue_valid, 0);
        step();
        // async reset mid-run
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("ar_pc2", bus.pc, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", bus.issue_valid, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_pc", bus.pc, 0);
        chk("ar_sel", sel, 0);
        chk("ar_done", bus.done, 0);
        chk("ar_error", bus.error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ar_ready", bus.load_ready, 1);
        chk("ar_idle", bus.busy, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ar_count0", bus.error, 1);
        step();
`ifdef ALU_SEQ_LOOP_EN
        bus.load_valid = 1'b1;
        bus.load_data = 8'h11;
        step();
        bus.load_data = 8'h22;
        step();
        bus.load_valid = 1'b0;
        bus.loop = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("lp_pc0", bus.pc, 0);
        chk("lp_sel0", sel, 8'h11);
        step();
        chk("lp_pc1", bus.pc, 1);
        chk("lp_sel1", sel, 8'h22);
        step();
        chk("lp_wrap_pc", bus.pc, 0);
        chk("lp_wrap_done", bus.done, 1);
        chk("lp_wrap_valid", bus.issue_valid, 1);
        step();
        chk("lp_pc1b", bus.pc, 1);
        chk("lp_done_off", bus.done, 0);
        step();
        chk("lp_wrap2_done", bus.done, 1);
        chk("lp_wrap2_pc", bus.pc, 0);
        bus.loop = 1'b0;
        step();
        chk("lp_last_pc", bus.pc, 1);
        step();
        chk("lp_end_done", bus.done, 1);
        chk("lp_end_valid", bus.issue_valid, 0);
        step();
        chk("lp_end_idle", bus.busy, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
